// File: rtl/lbi_row_pkg.sv
// Shared constants, sequencer state type and head-on pattern helper for lbi_row.
package lbi_row_pkg;

  localparam int NCELLS = 140;
  localparam int CELL_W = 6;
  localparam int RAND_W = 96;
  localparam int ROW_W  = NCELLS * CELL_W;
  localparam int IDX_W  = 8;
  localparam int BIT_W  = 10;
  localparam int RIDX_W = 7;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // A head-on pair is two particles in opposite directions, nothing else.
  function automatic logic is_head_on(input logic [CELL_W-1:0] c);
    return (c == 6'b001001) || (c == 6'b010010) || (c == 6'b100100);
  endfunction

endpackage

// File: rtl/lbi_cell_collide.sv
// Single-cell lattice-gas collision; the three-body rule is present only
// when LBI_ROW_THREE_BODY_EN is defined.
module lbi_cell_collide
  import lbi_row_pkg::*;
(
  input  logic [CELL_W-1:0] cell_i,
  input  logic              r_i,
  output logic [CELL_W-1:0] cell_o
);

  always_comb begin
    cell_o = cell_i;
    // r=0 rotates every particle +60 degrees, r=1 rotates -60 degrees.
    if (is_head_on(cell_i)) begin
      cell_o = r_i ? {cell_i[0], cell_i[5:1]} : {cell_i[4:0], cell_i[5]};
    end
`ifdef LBI_ROW_THREE_BODY_EN
    else if (cell_i == 6'b010101) begin
      cell_o = 6'b101010;
    end else if (cell_i == 6'b101010) begin
      cell_o = 6'b010101;
    end
`endif
  end

endmodule

// File: rtl/lbi_row.sv
// Row sequencer: latches one 140-cell lattice row and streams the collided
// cells out one per cycle. Three-body rule enabled by LBI_ROW_THREE_BODY_EN.
module lbi_row
  import lbi_row_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ROW_W-1:0]    msg_in,
  input  logic                valid,
  input  logic                start,
  input  logic [RAND_W-1:0]   randomin,
  output logic [CELL_W-1:0]   final_out,
  output logic                validout,
  output state_e              dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELLS - 1);
  localparam logic [IDX_W-1:0] RAND_N   = IDX_W'(RAND_W);

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [ROW_W-1:0]    row_q;
  logic [RAND_W-1:0]   rand_q;
  logic [CELL_W-1:0]   final_q;
  logic                vout_q;

  logic [BIT_W-1:0]    bit_idx;
  logic [RIDX_W-1:0]   rand_idx;
  logic [CELL_W-1:0]   cur_cell;
  logic                cur_r;
  logic [CELL_W-1:0]   coll_cell;

  // Index mux feeding the single shared collision unit.
  always_comb begin
    bit_idx  = BIT_W'(idx_q) * BIT_W'(CELL_W);
    rand_idx = (idx_q >= RAND_N) ? RIDX_W'(idx_q - RAND_N) : idx_q[RIDX_W-1:0];
    cur_cell = row_q[bit_idx +: CELL_W];
    cur_r    = rand_q[rand_idx];
  end

  lbi_cell_collide u_collide (
    .cell_i (cur_cell),
    .r_i    (cur_r),
    .cell_o (coll_cell)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      row_q   <= '0;
      rand_q  <= '0;
      final_q <= '0;
      vout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          final_q <= '0;
          vout_q  <= 1'b0;
          if (!start && valid) begin
            row_q   <= msg_in;
            rand_q  <= randomin;
            idx_q   <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (start) begin
            state_q <= IDLE;
            idx_q   <= '0;
            final_q <= '0;
            vout_q  <= 1'b0;
          end else begin
            final_q <= coll_cell;
            vout_q  <= 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          final_q <= '0;
          vout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign final_out = final_q;
  assign validout  = vout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lbi_row.sv
// Directed bench for lbi_row: reset, zero row, head-on / three-body cells,
// valid-ignore, abort, and mid-stream reset.
module tb_lbi_row;
  import lbi_row_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ROW_W-1:0]  msg_in = '0;
  logic              valid = 1'b0;
  logic              start = 1'b0;
  logic [RAND_W-1:0] randomin = '0;
  logic [CELL_W-1:0] final_out;
  logic              validout;
  state_e            dbg_state;

  int errors = 0;
  int checks = 0;

  logic [CELL_W-1:0] exp_q[$];
  logic [CELL_W-1:0] exp_cells[NCELLS];

  lbi_row dut (
    .clk       (clk),
    .rst       (rst),
    .msg_in    (msg_in),
    .valid     (valid),
    .start     (start),
    .randomin  (randomin),
    .final_out (final_out),
    .validout  (validout),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] put_cell(input logic [ROW_W-1:0] row, input int k,
                                                input logic [CELL_W-1:0] v);
    logic [ROW_W-1:0] r;
    r = row;
    r[k*CELL_W +: CELL_W] = v;
    return r;
  endfunction

  // Load a row, then score 140 output cycles against exp_cells. extra_valid keeps
  // valid high for that many cycles in total with junk data; abort_at >= 0 raises
  // start (together with valid) while that cell is on the output.
  task automatic run_row(input logic [ROW_W-1:0] msg, input logic [RAND_W-1:0] rnd,
                         input int extra_valid, input int abort_at);
    logic [CELL_W-1:0] e;
    exp_q.delete();
    for (int i = 0; i < NCELLS; i++) exp_q.push_back(exp_cells[i]);
    @(negedge clk);
    msg_in = msg; randomin = rnd; valid = 1'b1;
    @(negedge clk);
    msg_in = '1; randomin = '1; valid = (extra_valid > 1);
    check("pre_stream_validout", 32'(validout), 32'd0);
    for (int k = 0; k < NCELLS; k++) begin
      @(negedge clk);
      valid = (k < extra_valid - 2) || (k == NCELLS - 2);
      e = exp_q.pop_front();
      check($sformatf("validout[%0d]", k), 32'(validout), 32'd1);
      check($sformatf("cell[%0d]", k), 32'(final_out), 32'(e));
      if (k == abort_at) begin
        start = 1'b1; valid = 1'b1;
        @(negedge clk);
        start = 1'b0; valid = 1'b0;
        check("abort_validout", 32'(validout), 32'd0);
        check("abort_final", 32'(final_out), 32'd0);
        @(negedge clk);
        check("abort_no_load", 32'(validout), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        return;
      end
    end
    valid = 1'b0;
    @(negedge clk);
    check("end_validout", 32'(validout), 32'd0);
    check("end_final", 32'(final_out), 32'd0);
    @(negedge clk);
    check("end_stays_idle", 32'(validout), 32'd0);
  endtask

  initial begin
    logic [ROW_W-1:0]  row;
    logic [RAND_W-1:0] rnd;

    // Reset held with active inputs.
    valid = 1'b1;
    msg_in = {27{$urandom}};
    randomin = {$urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    check("rst_final", 32'(final_out), 32'd0);
    check("rst_validout", 32'(validout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    valid = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_validout", 32'(validout), 32'd0);
      check("post_rst_final", 32'(final_out), 32'd0);
    end

    // All-zero row.
    for (int i = 0; i < NCELLS; i++) exp_cells[i] = '0;
    run_row('0, '0, 1, -1);

    // Head-on and three-body cells; valid held 3 cycles and during last cell.
    row = '0;
    row = put_cell(row, 0, 6'b001001);
    row = put_cell(row, 1, 6'b010101);
    row = put_cell(row, 2, 6'b000111);
    row = put_cell(row, 3, 6'b100100);
    row = put_cell(row, 4, 6'b101010);
    row = put_cell(row, 100, 6'b010010);
    row = put_cell(row, 139, 6'b111000);
    rnd = '0;
    rnd[3] = 1'b1;
    rnd[4] = 1'b1;
    for (int i = 0; i < NCELLS; i++) exp_cells[i] = '0;
    exp_cells[0] = 6'b010010;
`ifdef LBI_ROW_THREE_BODY_EN
    exp_cells[1] = 6'b101010;
    exp_cells[4] = 6'b010101;
`else
    exp_cells[1] = 6'b010101;
    exp_cells[4] = 6'b101010;
`endif
    exp_cells[2]   = 6'b000111;
    exp_cells[3]   = 6'b010010;
    exp_cells[100] = 6'b001001;
    exp_cells[139] = 6'b111000;
    run_row(row, rnd, 3, -1);

    // Same row with randomin[0]=1: cell0 rotates the other way.
    rnd[0] = 1'b1;
    exp_cells[0] = 6'b100100;
    run_row(row, rnd, 1, -1);

    // Abort at cell 50, then a fresh load.
    run_row(row, rnd, 1, 50);
    rnd[0] = 1'b0;
    exp_cells[0] = 6'b010010;
    run_row(row, rnd, 1, -1);

    // Reset mid-stream abandons the row.
    @(negedge clk);
    msg_in = row; randomin = rnd; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_pre_validout", 32'(validout), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_validout", 32'(validout), 32'd0);
    check("mid_rst_final", 32'(final_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("mid_rst_no_resume", 32'(validout), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
